// File: rtl/blue_pkg.sv
// Shared definitions for the blue micro-sequencer: instruction classes,
// field positions, FSM states and ZNC flag indices.
package blue_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LDI  = 2'b01,
    CLS_BR   = 2'b10,
    CLS_HALT = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam int CLS_HI   = 31;
  localparam int CLS_LO   = 30;
  localparam int DST_HI   = 29;
  localparam int DST_LO   = 28;
  localparam int SRCA_HI  = 27;
  localparam int SRCA_LO  = 26;
  localparam int SRCB_HI  = 25;
  localparam int SRCB_LO  = 24;
  localparam int PAIR_BIT = 23;
  localparam int MASK_HI  = 26;
  localparam int MASK_LO  = 24;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  // Flag ordering matches the datapath ZNC bus.
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/blue_regfile.sv
// 4x16 register file: two operand read ports, one debug read port,
// a primary write port and a pair write port that commit on the same edge.
module blue_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ra_sel_i,
  input  logic [1:0]  rb_sel_i,
  input  logic [1:0]  dbg_sel_i,
  output logic [15:0] ra_data_o,
  output logic [15:0] rb_data_o,
  output logic [15:0] dbg_data_o,
  input  logic        wa_en_i,
  input  logic [1:0]  wa_sel_i,
  input  logic [15:0] wa_data_i,
  input  logic        wb_en_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_data_i
);

  logic [15:0] regs_q [4];

  // NOTE: this array is four flops, not a RAM macro, so it takes the async
  // reset like any other state; a real memory would be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      if (wa_en_i) regs_q[wa_sel_i] <= wa_data_i;
      if (wb_en_i) regs_q[wb_sel_i] <= wb_data_i;
    end
  end

  assign ra_data_o  = regs_q[ra_sel_i];
  assign rb_data_o  = regs_q[rb_sel_i];
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/blue_seq.sv
// Micro-sequencer that fetches instructions from external program memory
// and drives the blue ALU datapath, with LDI, ZNC branches and step-limit abort.
module blue_seq
  import blue_pkg::*;
#(
  parameter int PROG_AW   = 6,
  parameter int MAX_STEPS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PROG_AW-1:0] prog_base,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [PROG_AW-1:0] prog_addr,
  input  logic [31:0]        prog_data,
  output logic [15:0]        blue_op,
  output logic [15:0]        blue_a,
  output logic [15:0]        blue_b,
  output logic [2:0]         blue_znc_in,
  input  logic [15:0]        blue_a_res,
  input  logic [15:0]        blue_b_res,
  input  logic [2:0]         blue_znc_res,
  input  logic [1:0]         rd_sel,
  output logic [15:0]        rd_data,
  output logic [2:0]         znc
);

  state_e             state_q;
  logic [PROG_AW-1:0] pc_q;
  logic [16:0]        step_q;
  logic               err_q;
  logic [2:0]         znc_q;

  cls_e               cls;
  logic [1:0]         dst;
  logic [1:0]         src_a;
  logic [1:0]         src_b;
  logic               pair;
  logic [2:0]         mask;
  logic [15:0]        imm;
  logic [PROG_AW-1:0] target;
  logic               in_exec;
  logic               br_taken;
  logic               last_step;
  logic [PROG_AW-1:0] pc_inc;
  logic [15:0]        ra_data;
  logic [15:0]        rb_data;
  logic               wa_en;
  logic [15:0]        wa_data;
  logic               wb_en;
  logic               unused_insn_bits;

  assign cls    = cls_e'(prog_data[CLS_HI:CLS_LO]);
  assign dst    = prog_data[DST_HI:DST_LO];
  assign src_a  = prog_data[SRCA_HI:SRCA_LO];
  assign src_b  = prog_data[SRCB_HI:SRCB_LO];
  assign pair   = prog_data[PAIR_BIT];
  assign mask   = prog_data[MASK_HI:MASK_LO];
  assign imm    = prog_data[IMM_HI:IMM_LO];
  assign target = prog_data[PROG_AW-1:0];
  assign unused_insn_bits = &{1'b0, prog_data[22:16]};

  assign in_exec   = (state_q == EXEC);
  assign pc_inc    = pc_q + 1'b1;
  assign br_taken  = (mask == 3'b000) || ((znc_q & mask) != 3'b000);
  assign last_step = ((step_q + 17'd1) == 17'(MAX_STEPS));

  // Operands are read at the start of EXEC, so a pair write aliasing a
  // source still sees the old value; both writes land on the same edge.
  assign wa_en   = in_exec && ((cls == CLS_ALU) || (cls == CLS_LDI));
  assign wa_data = (cls == CLS_LDI) ? imm : blue_a_res;
  assign wb_en   = in_exec && (cls == CLS_ALU) && pair;

  blue_regfile u_regfile (
    .clk        (clk),
    .reset      (reset),
    .ra_sel_i   (src_a),
    .rb_sel_i   (src_b),
    .dbg_sel_i  (rd_sel),
    .ra_data_o  (ra_data),
    .rb_data_o  (rb_data),
    .dbg_data_o (rd_data),
    .wa_en_i    (wa_en),
    .wa_sel_i   (dst),
    .wa_data_i  (wa_data),
    .wb_en_i    (wb_en),
    .wb_sel_i   (dst ^ 2'b01),
    .wb_data_i  (blue_b_res)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge values of the other registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      step_q  <= '0;
      err_q   <= 1'b0;
      znc_q   <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pc_q    <= prog_base;
            step_q  <= '0;
            err_q   <= 1'b0;
            state_q <= FETCH;
          end
        end
        FETCH: state_q <= EXEC;
        EXEC: begin
          step_q <= step_q + 17'd1;
          case (cls)
            CLS_ALU: begin
              znc_q <= blue_znc_res;
              pc_q  <= pc_inc;
            end
            CLS_LDI: pc_q <= pc_inc;
            CLS_BR:  pc_q <= br_taken ? target : pc_inc;
            default: ;
          endcase
          if (cls == CLS_HALT) begin
            state_q <= DONE;
          end else if (last_step) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == FETCH) || (state_q == EXEC);
  assign done        = (state_q == DONE);
  assign err         = err_q;
  assign prog_addr   = pc_q;
  assign blue_op     = in_exec ? imm : 16'h0000;
  assign blue_a      = in_exec ? ra_data : 16'h0000;
  assign blue_b      = in_exec ? rb_data : 16'h0000;
  assign blue_znc_in = znc_q;
  assign znc         = znc_q;

endmodule

// File: tb/tb_blue_seq.sv
// Directed bench for blue_seq with a behavioural program memory and an
// add/subtract datapath stub.
module tb_blue_seq;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] prog_base = '0;
  logic          busy, done, err;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [15:0]   blue_op, blue_a, blue_b;
  logic [2:0]    blue_znc_in;
  logic [15:0]   blue_a_res, blue_b_res;
  logic [2:0]    blue_znc_res;
  logic [1:0]    rd_sel = 2'd0;
  logic [15:0]   rd_data;
  logic [2:0]    znc;

  logic [31:0]   mem [64];
  logic [16:0]   sum;

  int total = 0;
  int bad   = 0;
  int addr_trace [64];
  logic overlap;
  logic err_first;

  always #5 clk = ~clk;

  blue_seq #(.PROG_AW(AW), .MAX_STEPS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .prog_base    (prog_base),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .blue_op      (blue_op),
    .blue_a       (blue_a),
    .blue_b       (blue_b),
    .blue_znc_in  (blue_znc_in),
    .blue_a_res   (blue_a_res),
    .blue_b_res   (blue_b_res),
    .blue_znc_res (blue_znc_res),
    .rd_sel       (rd_sel),
    .rd_data      (rd_data),
    .znc          (znc)
  );

  always @(posedge clk) prog_data <= mem[prog_addr];

  always_comb begin
    sum          = {1'b0, blue_a} + {1'b0, blue_b};
    blue_a_res   = sum[15:0];
    blue_b_res   = blue_a - blue_b;
    blue_znc_res = {sum[15:0] == 16'h0000, sum[15], sum[16]};
  end

  function automatic logic [31:0] ldi(input logic [1:0] d, input logic [15:0] v);
    return {2'b01, d, 12'h000, v};
  endfunction

  function automatic logic [31:0] alu(input logic [1:0] d, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic p);
    return {2'b00, d, sa, sb, p, 7'h00, 16'h0001};
  endfunction

  function automatic logic [31:0] br(input logic [2:0] m, input logic [AW-1:0] t);
    return {2'b10, 3'b000, m, 18'h00000, t};
  endfunction

  localparam logic [31:0] HALT = {2'b11, 30'h0};

  // Starts a run at base and returns the cycle index n of done (start accepted in cycle 0).
  task automatic run_prog(input logic [AW-1:0] base, input int pulse_at,
                          output int n, output logic err_seen);
    @(negedge clk);
    prog_base = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    overlap = 1'b0;
    err_first = err;
    while (!done && n < 200) begin
      if (n < 64) addr_trace[n] = prog_addr;
      if (busy && done) overlap = 1'b1;
      if (n == pulse_at) begin
        start = 1'b1;
        prog_base = 6'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy && done) overlap = 1'b1;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL run_timeout: base=%0d no done after %0d cycles", base, n);
    end
    err_seen = err;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] r, input logic [15:0] exp);
    rd_sel = r;
    #1;
    total++;
    if (rd_data !== exp) begin
      bad++;
      $display("FAIL %s: R%0d got %h want %h", name, r, rd_data, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, err, prog_addr, blue_op, blue_a, blue_b, znc} !== '0) begin
      bad++;
      $display("FAIL reset_held: outputs got busy=%b done=%b err=%b addr=%0d op=%h znc=%b want all 0",
               busy, done, err, prog_addr, blue_op, znc);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, znc} !== 5'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b done=%b znc=%b want 0", busy, done, znc);
    end
    for (int i = 0; i < 4; i++) chk_reg("reset_regs", 2'(i), 16'h0000);
  endtask

  task automatic test_alu_pair;
    int n;
    logic e;
    mem[4] = ldi(2'd0, 16'd5);
    mem[5] = ldi(2'd1, 16'd3);
    mem[6] = alu(2'd2, 2'd0, 2'd1, 1'b1);
    mem[7] = HALT;
    run_prog(6'd4, 0, n, e);
    total++;
    if (n !== 9) begin
      bad++;
      $display("FAIL alu_latency: done at t+%0d want t+9", n);
    end
    total++;
    if (e !== 1'b0 || znc !== 3'b000 || overlap !== 1'b0) begin
      bad++;
      $display("FAIL alu_flags: err=%b znc=%b overlap=%b want 0 000 0", e, znc, overlap);
    end
    chk_reg("alu_r0", 2'd0, 16'd5);
    chk_reg("alu_r1", 2'd1, 16'd3);
    chk_reg("alu_r2", 2'd2, 16'd8);
    chk_reg("alu_r3", 2'd3, 16'd2);
  endtask

  task automatic test_branch;
    int n;
    logic e;
    mem[0]  = ldi(2'd0, 16'd0);
    mem[1]  = ldi(2'd1, 16'd0);
    mem[2]  = alu(2'd2, 2'd0, 2'd1, 1'b0);
    mem[3]  = br(3'b100, 6'd10);
    mem[4]  = HALT;
    mem[10] = HALT;
    run_prog(6'd0, 0, n, e);
    total++;
    if (n !== 11 || addr_trace[9] !== 10 || znc !== 3'b100) begin
      bad++;
      $display("FAIL br_taken: done t+%0d addr %0d znc %b want t+11 10 100", n, addr_trace[9], znc);
    end
    mem[0] = ldi(2'd0, 16'd1);
    run_prog(6'd0, 0, n, e);
    total++;
    if (n !== 11 || addr_trace[9] !== 4 || znc !== 3'b000) begin
      bad++;
      $display("FAIL br_not_taken: done t+%0d addr %0d znc %b want t+11 4 000", n, addr_trace[9], znc);
    end
    chk_reg("br_r2", 2'd2, 16'd1);
  endtask

  task automatic test_abort;
    int n;
    logic e;
    mem[20] = br(3'b000, 6'd20);
    run_prog(6'd20, 0, n, e);
    total++;
    if (n !== 33 || e !== 1'b1) begin
      bad++;
      $display("FAIL abort: done t+%0d err %b want t+33 1", n, e);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_hold: err=%b busy=%b want 1 0", err, busy);
    end
    mem[4] = ldi(2'd0, 16'd5);
    run_prog(6'd4, 0, n, e);
    total++;
    if (err_first !== 1'b0 || e !== 1'b0 || n !== 9) begin
      bad++;
      $display("FAIL abort_clear: err t+1=%b done err=%b done t+%0d want 0 0 9", err_first, e, n);
    end
  endtask

  task automatic test_wrap;
    int n;
    logic e;
    mem[63] = ldi(2'd1, 16'h1234);
    mem[0]  = HALT;
    run_prog(6'd63, 2, n, e);
    total++;
    if (addr_trace[1] !== 63 || addr_trace[3] !== 0 || n !== 5) begin
      bad++;
      $display("FAIL wrap: fetch %0d,%0d done t+%0d want 63,0 t+5", addr_trace[1], addr_trace[3], n);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL start_ignored: busy=%b done=%b want 0 0", busy, done);
    end
    chk_reg("wrap_r1", 2'd1, 16'h1234);
  endtask

  task automatic test_reset_exec;
    mem[30] = ldi(2'd0, 16'hBEEF);
    @(negedge clk);
    prog_base = 6'd30;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (blue_op !== 16'hBEEF || busy !== 1'b1) begin
      bad++;
      $display("FAIL exec_ldi: op=%h busy=%b want beef 1", blue_op, busy);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, err, prog_addr, blue_op, blue_a, blue_b, znc} !== '0) begin
      bad++;
      $display("FAIL reset_exec_outputs: busy=%b done=%b addr=%0d op=%h want all 0",
               busy, done, prog_addr, blue_op);
    end
    @(negedge clk);
    reset = 1'b0;
    chk_reg("reset_exec_r0", 2'd0, 16'h0000);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_exec_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = HALT;
      addr_trace[i] = 0;
    end
    test_reset;
    test_alu_pair;
    test_branch;
    test_abort;
    test_wrap;
    test_reset_exec;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
